// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave backed by a word-addressed register memory.
// Returns prdata/pready/pslverr, inserts programmable wait states and flags
// misaligned or out-of-range addresses with pslverr.
//
// Optional feature macro: APB_SLV_WAIT_EN
//   defined   - a wait counter holds each ACCESS phase for WAIT_CYCLES
//               extra cycles before pready rises.
//   undefined - no wait counter is built; pready rises in the first
//               ACCESS cycle and WAIT_CYCLES is ignored.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer in progress; waiting for a SETUP (psel & !penable)
// ACCESS | SETUP seen; counting wait states, completing on the handshake
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclock,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            wr_count,
  output logic [7:0]            rd_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Parameter sanity checks at elaboration time.
  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_slave_mem: MEM_DEPTH must be a power of 2, at least 2");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_slave_mem: WAIT_CYCLES must be in 0..15");
  end
  if (ADDR_WIDTH <= IDX_W + 2) begin : g_bad_addr
    $error("apb_slave_mem: ADDR_WIDTH too small for MEM_DEPTH");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [IDX_W-1:0]        idx;
  logic                    addr_err;
  logic                    wr_ok;
  logic                    rd_ok;

`ifdef APB_SLV_WAIT_EN
  logic [3:0]              cnt;
`endif

  // Address decode: word index plus misaligned / out-of-range detection.
  // MEM_DEPTH is a power of two, so "paddr >= MEM_DEPTH*4" is simply any
  // address bit above the index field being set.
  always_comb begin
    idx      = paddr[IDX_W+1:2];
    addr_err = (|paddr[1:0]) | (|paddr[ADDR_WIDTH-1:IDX_W+2]);
  end

  // Handshake and response signals, combinational from the registered state.
  always_comb begin
`ifdef APB_SLV_WAIT_EN
    pready = (state == ACCESS) & psel & penable & (cnt == 4'd0);
`else
    pready = (state == ACCESS) & psel & penable;
`endif
    pslverr = pready & addr_err;
    wr_ok   = pready & pwrite & ~addr_err;
    rd_ok   = pready & ~pwrite & ~addr_err;
    prdata  = rd_ok ? mem[idx] : '0;
  end

  // Transfer FSM: SETUP moves to ACCESS, handshake or dropped psel returns
  // to IDLE so a back-to-back SETUP is caught on the very next cycle.
  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      state <= IDLE;
`ifdef APB_SLV_WAIT_EN
      cnt   <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state <= ACCESS;
`ifdef APB_SLV_WAIT_EN
            cnt   <= 4'(WAIT_CYCLES);
`endif
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (pready) begin
            state <= IDLE;
          end
`ifdef APB_SLV_WAIT_EN
          else if (penable && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register memory: written only on an error-free write handshake.
  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[idx] <= pwdata;
    end
  end

  // Successful-transfer counters, wrapping at 255.
  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      wr_count <= 8'd0;
      rd_count <= 8'd0;
    end else begin
      if (wr_ok) wr_count <= wr_count + 8'd1;
      if (rd_ok) rd_count <= rd_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed bench for apb_slave_mem (MEM_DEPTH=16,
// WAIT_CYCLES=2). Expected ACCESS latency follows APB_SLV_WAIT_EN.
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        pclock;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  wr_count;
  logic [7:0]  rd_count;

  int checks = 0;
  int passes = 0;

  apb_slave_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (16),
    .WAIT_CYCLES(2)
  ) dut (
    .pclock  (pclock),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .wr_count(wr_count),
    .rd_count(rd_count)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One APB transfer: SETUP, then ACCESS until pready (max 20 cycles).
  // Returns at the falling edge of the handshake cycle; cyc=0 on timeout.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata, output logic err, output int cyc);
    @(posedge pclock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclock); #1;
    penable = 1'b1;
    cyc = 0; rdata = 'x; err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge pclock);
      if (pready === 1'b1) begin
        cyc = k; rdata = prdata; err = pslverr;
        break;
      end
      @(posedge pclock); #1;
    end
  endtask

  task automatic go_idle();
    @(posedge pclock); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          cy;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    #1;
    check("rst_pready",   {31'd0, pready},  32'd0);
    check("rst_pslverr",  {31'd0, pslverr}, 32'd0);
    check("rst_prdata",   prdata,           32'd0);
    check("rst_wr_count", {24'd0, wr_count}, 32'd0);
    check("rst_rd_count", {24'd0, rd_count}, 32'd0);
    @(negedge pclock); @(negedge pclock);
    preset = 1'b0;

    // Write then read back 0x8.
    xfer(1'b1, 32'h8, 32'hDEADBEEF, rd, er, cy);
    check("wr8_latency", cy, LAT);
    check("wr8_pslverr", {31'd0, er}, 32'd0);
    go_idle();
    check("wr8_wr_count", {24'd0, wr_count}, 32'd1);
    xfer(1'b0, 32'h8, 32'h0, rd, er, cy);
    check("rd8_latency", cy, LAT);
    check("rd8_prdata",  rd, 32'hDEADBEEF);
    check("rd8_pslverr", {31'd0, er}, 32'd0);
    go_idle();
    check("rd8_rd_count", {24'd0, rd_count}, 32'd1);
    check("rd8_wr_count", {24'd0, wr_count}, 32'd1);

    // Back-to-back writes then back-to-back reads, no IDLE in between.
    xfer(1'b1, 32'h0, 32'h11, rd, er, cy);
    check("b2b_wr0_latency", cy, LAT);
    xfer(1'b1, 32'h4, 32'h22, rd, er, cy);
    check("b2b_wr1_latency", cy, LAT);
    xfer(1'b0, 32'h0, 32'h0, rd, er, cy);
    check("b2b_rd0_latency", cy, LAT);
    check("b2b_rd0_data", rd, 32'h11);
    xfer(1'b0, 32'h4, 32'h0, rd, er, cy);
    check("b2b_rd1_latency", cy, LAT);
    check("b2b_rd1_data", rd, 32'h22);
    go_idle();
    check("b2b_wr_count", {24'd0, wr_count}, 32'd3);
    check("b2b_rd_count", {24'd0, rd_count}, 32'd3);

    // Misaligned write to 0x6 must not touch mem[1].
    xfer(1'b1, 32'h6, 32'hFFFF_FFFF, rd, er, cy);
    check("mis_latency", cy, LAT);
    check("mis_pslverr", {31'd0, er}, 32'd1);
    go_idle();
    check("mis_wr_count", {24'd0, wr_count}, 32'd3);
    xfer(1'b0, 32'h4, 32'h0, rd, er, cy);
    check("mis_mem1", rd, 32'h22);
    go_idle();
    check("mis_rd_count", {24'd0, rd_count}, 32'd4);

    // Out-of-range read at 0x40.
    xfer(1'b0, 32'h40, 32'h0, rd, er, cy);
    check("oor_latency", cy, LAT);
    check("oor_pslverr", {31'd0, er}, 32'd1);
    check("oor_prdata",  rd, 32'h0);
    go_idle();
    check("oor_rd_count", {24'd0, rd_count}, 32'd4);

    // ACCESS-style request without SETUP from IDLE is ignored.
    @(posedge pclock); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h99;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclock);
      check("viol_pready", {31'd0, pready}, 32'd0);
    end
    go_idle();
    check("viol_wr_count", {24'd0, wr_count}, 32'd3);

    // Reset asserted in the first ACCESS cycle of a write to 0xC.
    @(posedge pclock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hCAFE_F00D;
    @(posedge pclock); #1;
    penable = 1'b1;
    #2 preset = 1'b1;
    #1;
    check("rstmid_pready", {31'd0, pready}, 32'd0);
    check("rstmid_wr_count", {24'd0, wr_count}, 32'd0);
    @(posedge pclock); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclock);
    preset = 1'b0;
    xfer(1'b0, 32'hC, 32'h0, rd, er, cy);
    check("rstmid_rdC_latency", cy, LAT);
    check("rstmid_rdC_data", rd, 32'h0);
    xfer(1'b0, 32'h8, 32'h0, rd, er, cy);
    check("rstmid_rd8_data", rd, 32'h0);
    go_idle();
    check("rstmid_wr_count_after", {24'd0, wr_count}, 32'd0);
    check("rstmid_rd_count_after", {24'd0, rd_count}, 32'd2);

    // wr_count wraps 255 -> 0.
    for (int i = 0; i < 255; i++) begin
      xfer(1'b1, 32'h0, i, rd, er, cy);
    end
    go_idle();
    check("wrap_wr_count_255", {24'd0, wr_count}, 32'd255);
    xfer(1'b1, 32'h3C, 32'h1234_5678, rd, er, cy);
    go_idle();
    check("wrap_wr_count_0", {24'd0, wr_count}, 32'd0);
    xfer(1'b0, 32'h0, 32'h0, rd, er, cy);
    check("wrap_mem0", rd, 32'd254);
    xfer(1'b0, 32'h3C, 32'h0, rd, er, cy);
    check("wrap_mem15", rd, 32'h1234_5678);
    go_idle();
    check("wrap_rd_count", {24'd0, rd_count}, 32'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
